// File: rtl/prbs8_pkg.sv
// prbs8_pkg: shared FSM state type, LFSR taps and PRBS8 helper functions
package prbs8_pkg;
  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} state_t;
  localparam logic [7:0] TAPS = 8'hB8;
  function automatic logic [7:0] next8(input logic [7:0] w);
    return {w[6:0], ^(w & TAPS)};
  endfunction
  function automatic logic [3:0] popcount8(input logic [7:0] w);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b0, w[i]};
    return c;
  endfunction
endpackage

// File: rtl/prbs8_sat_counter.sv
// prbs8_sat_counter: saturating up-counter with variable increment and sync clear
module prbs8_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] inc,
  output logic [W-1:0] cnt
);
  logic [W:0] sum;
  assign sum = {1'b0, cnt} + {1'b0, inc};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= sum[W] ? '1 : sum[W-1:0];
endmodule

// File: rtl/prbs8_checker.sv
// prbs8_checker: self-synchronising PRBS8 checker with flywheel lock and error counters
module prbs8_checker
  import prbs8_pkg::*;
#(
  parameter int LOCK_CNT   = 4,
  parameter int UNLOCK_CNT = 3,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         data_in,
  input  logic               data_valid,
  input  logic               clr_cnt,
  output logic               locked,
  output logic               err_pulse,
  output logic [CNT_W-1:0]   err_word_cnt,
  output logic [CNT_W+3:0]   err_bit_cnt
);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int UW = $clog2(UNLOCK_CNT + 1);
  state_t         state, state_nx;
  logic [7:0]     prev, prev_nx, exp, exp_nx;
  logic [MW-1:0]  match_cnt, match_nx;
  logic [UW-1:0]  bad_cnt, bad_nx;
  logic           err_nx, hit, miss;
  assign hit    = data_in == next8(prev) && data_in != 8'h00;
  assign miss   = data_in != exp;
  assign locked = state == LOCKED;
  always_comb begin
    state_nx = state;
    prev_nx  = prev;
    exp_nx   = exp;
    match_nx = match_cnt;
    bad_nx   = bad_cnt;
    err_nx   = 1'b0;
    if (data_valid)
      case (state)
        IDLE: begin
          prev_nx  = data_in;
          match_nx = '0;
          state_nx = SEARCH;
        end
        SEARCH: begin
          prev_nx  = data_in;
          match_nx = hit ? match_cnt + MW'(1) : '0;
          if (hit && match_cnt == MW'(LOCK_CNT - 1)) begin
            state_nx = LOCKED;
            exp_nx   = next8(data_in);
            match_nx = '0;
          end
        end
        LOCKED: begin
          // flywheel: prediction runs from its own history, never from received data
          exp_nx = next8(exp);
          err_nx = miss;
          bad_nx = miss ? bad_cnt + UW'(1) : '0;
          if (miss && bad_cnt == UW'(UNLOCK_CNT - 1)) begin
            state_nx = SEARCH;
            prev_nx  = data_in;
            match_nx = '0;
            bad_nx   = '0;
          end
        end
        default: state_nx = IDLE;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      prev      <= '0;
      exp       <= '0;
      match_cnt <= '0;
      bad_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      state     <= state_nx;
      prev      <= prev_nx;
      exp       <= exp_nx;
      match_cnt <= match_nx;
      bad_cnt   <= bad_nx;
      err_pulse <= err_nx;
    end
  prbs8_sat_counter #(.W(CNT_W)) u_word_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .en(err_nx),
    .inc(CNT_W'(1)), .cnt(err_word_cnt)
  );
  prbs8_sat_counter #(.W(CNT_W + 4)) u_bit_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr_cnt), .en(err_nx),
    .inc((CNT_W + 4)'(popcount8(data_in ^ exp))), .cnt(err_bit_cnt)
  );
endmodule

// File: doc/prbs8_checker.md
PRBS8_CHECKER -- requirements
Module: prbs8_checker

Interface
REQ-001 Parameter LOCK_CNT, default 4: consecutive correctly predicted words needed to lock.
REQ-002 Parameter UNLOCK_CNT, default 3: consecutive mismatched words while locked that force loss of lock.
REQ-003 Parameter CNT_W, default 16: width of the word-error counter; bit-error counter is CNT_W+4.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 data_in  input  8  received PRBS word from the 8-bit LFSR stage.
REQ-007 data_valid  input  1  qualifies data_in for one cycle; equivalent of the generator's clk_en.
REQ-008 clr_cnt  input  1  synchronous clear of both error counters.
REQ-009 locked  output  1  high while the FSM is in LOCKED.
REQ-010 err_pulse  output  1  one-cycle pulse per mismatched word while locked.
REQ-011 err_word_cnt  output  CNT_W  saturating count of mismatched words.
REQ-012 err_bit_cnt  output  CNT_W+4  saturating count of mismatched bits.

Function
REQ-013 Successor function: next(w) = {w[6:0], w[7]^w[5]^w[4]^w[3]}, matching the upstream generator exactly.
REQ-014 Input words are consumed only on cycles with data_valid=1; cycles with data_valid=0 change no state and no counter.
REQ-015 FSM states: IDLE (no previous word held), SEARCH (self-synchronising), LOCKED (flywheel).
REQ-016 IDLE: on a valid word, store it as prev and go to SEARCH with match_cnt=0.
REQ-017 SEARCH: on a valid word w, it is a match when w == next(prev) and w != 8'h00.
REQ-018 SEARCH: a match increments match_cnt; a non-match sets match_cnt to 0; prev <= w in both cases.
REQ-019 SEARCH: on the edge where match_cnt would reach LOCK_CNT, go to LOCKED and set exp <= next(w).
REQ-020 LOCKED: each valid word w is compared with exp, then exp <= next(exp). The prediction never reloads from received data.
REQ-021 LOCKED mismatch: err_pulse=1 on the following cycle, err_word_cnt+1, err_bit_cnt + popcount(w^exp), bad_cnt+1.
REQ-022 LOCKED match: bad_cnt <= 0.
REQ-023 LOCKED: on the edge where bad_cnt would reach UNLOCK_CNT, go to SEARCH with match_cnt=0 and prev <= w.
REQ-024 Mismatches in IDLE or SEARCH are not counted and raise no err_pulse.
REQ-025 Latency: locked, err_pulse and the counters update on the clock edge that samples the qualifying word. Outputs are registered, so a change is visible one cycle after data_valid.
REQ-026 Counters saturate at all-ones and never wrap.
REQ-027 When clr_cnt and an error occur in the same cycle, the clear wins; that cycle's error is not counted, but err_pulse is still raised.
REQ-028 clr_cnt does not affect FSM state, exp, prev, match_cnt or bad_cnt.
REQ-029 An all-zero word while LOCKED is treated as an ordinary mismatch (8 bit errors if exp has all bits set, otherwise popcount(exp)).

Reset
REQ-030 While rst_n=0: state=IDLE, prev=0, exp=0, match_cnt=0, bad_cnt=0, locked=0, err_pulse=0, err_word_cnt=0, err_bit_cnt=0.
REQ-031 Reset asserted mid-lock drops locked within the same cycle, without waiting for a clock edge.
REQ-032 After release, relocking requires a fresh IDLE→SEARCH→LOCKED sequence.

Structure
REQ-033 A shared package prbs8_pkg holds:
- the FSM state typedef (IDLE, SEARCH, LOCKED);
- tap constant 8'hB8 (bits 7,5,4,3);
- the next() function;
- a popcount8 function.
REQ-034 One sub-module, prbs8_sat_counter (parameterised width, increment amount, synchronous clear, saturation), is instantiated twice, once for each error counter.

Verification
REQ-035 Clean lock: after reset, stream FF,FE,FC,F8,F0 -> locked rises one cycle after F0 is sampled; counters stay 0.
REQ-036 Single bit error: when locked, send E0 where E1 is expected, then continue the correct sequence -> err_pulse once, err_word_cnt=1, err_bit_cnt=1, locked stays 1.
REQ-037 Loss of lock: when locked, send 3 consecutive 00 words -> err_word_cnt=3, locked falls after the third word; a correct stream then relocks after LOCK_CNT matches.
REQ-038 Gapped valid: the clean stream with data_valid low on alternate cycles -> the same lock point in words, and no errors.
REQ-039 clr_cnt collides with an error word, and an async reset pulse is applied mid-lock -> counters read 0 after the collision; locked=0 immediately on rst_n low.
REQ-040 Saturation: with CNT_W=4, force 20 error words while keeping lock by alternating one good and one bad word -> err_word_cnt holds at 15 and never wraps.
